mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand/HI/LO width (even, >= 4).
REQ-002 Derived: CW = clog2(WIDTH+1), iteration counter width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  request new operation; sampled only in IDLE.
REQ-006 op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-007 A  in  WIDTH  multiplicand / dividend (rs).
REQ-008 B  in  WIDTH  multiplier / divisor (rt).
REQ-009 abort  in  1  flush in-flight operation (pipeline exception/flush).
REQ-010 hi_we  in  1  MTHI write enable.
REQ-011 lo_we  in  1  MTLO write enable.
REQ-012 wdata  in  WIDTH  MTHI/MTLO write data.
REQ-013 busy  out  1  operation in flight; pipeline stalls MFHI/MFLO/next mul-div while high.
REQ-014 done  out  1  single-cycle pulse, HI/LO just updated by a completed operation.
REQ-015 hi  out  WIDTH  HI register (MULT upper half / DIV remainder).
REQ-016 lo  out  WIDTH  LO register (MULT lower half / DIV quotient).

Function
REQ-017 FSM states SHALL be IDLE, CALC, FIX; encoding free.
REQ-018 IDLE: start=1 -> latch |A|,|B| (signed ops) or A,B (unsigned ops), result sign flags, op; counter=WIDTH; go CALC.
REQ-019 CALC: one radix-2 step per cycle (shift-add multiply; restoring divide); counter decrements; counter reaching 0 -> FIX.
REQ-020 FIX: apply sign correction, write HI/LO, go IDLE.
REQ-021 Timing: start sampled at edge k -> busy=1 for cycles k+1 .. k+WIDTH+1; HI/LO valid and done=1 in cycle k+WIDTH+2; busy=0 in that cycle; latency WIDTH+2.
REQ-022 done SHALL be high exactly one cycle per completed operation, never after abort.
REQ-023 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, two's-complement for MULT.
REQ-024 DIV: quotient truncates toward zero; remainder takes dividend's sign; |remainder| < |divisor|.
REQ-025 Divide by zero (DIV, DIVU): lo = all ones, hi = A; normal latency, done pulses.
REQ-026 Signed overflow (DIV, A = 1 followed by zeros, B = all ones): lo = A, hi = 0.
REQ-027 start while busy SHALL be ignored (no queueing).
REQ-028 abort=1 in CALC or FIX -> IDLE next edge, busy=0 next cycle, HI/LO unchanged, no done; abort in IDLE has no effect; abort beats start in the same cycle.
REQ-029 hi_we/lo_we in IDLE: write wdata next edge; both may assert together.
REQ-030 hi_we/lo_we while busy SHALL be ignored.
REQ-031 start and hi_we/lo_we in the same IDLE cycle: start wins, write discarded.
REQ-032 hi/lo SHALL change only on FIX completion, accepted MTHI/MTLO, or reset.

Reset
REQ-033 rst_n=0 at a clock edge -> state IDLE, counter 0, hi=0, lo=0, busy=0, done=0; overrides all other inputs.
REQ-034 Reset mid-operation SHALL discard the operation with no done pulse; the first start after rst_n returns high is accepted normally.

Verification (WIDTH=32)
REQ-035 MULT, A=FFFFFFFE, B=00000003 -> hi=FFFFFFFF, lo=FFFFFFFA; done exactly 34 cycles after start edge; busy high 33 cycles.
REQ-036 MULTU, A=FFFFFFFF, B=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; a second start issued while busy is ignored (one done only).
REQ-037 DIV, A=FFFFFFF9, B=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU same operands -> lo=7FFFFFFC, hi=00000001.
REQ-038 DIVU, A=12345678, B=0 -> lo=FFFFFFFF, hi=12345678; DIV, A=80000000, B=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-039 MTHI wdata=AAAA5555 in IDLE -> hi=AAAA5555; then MULTU with abort at 10th busy cycle -> busy=0 next cycle, no done, hi=AAAA5555 retained.
REQ-040 rst_n low during 20th busy cycle of DIV -> hi=lo=0, busy=done=0 next cycle; following MULT 00000005 x 00000007 -> lo=00000023, hi=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide.
// Signed operations run on magnitudes and fix the signs in a final cycle.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             abort,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  // Two's-complement negation of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + ONE_W;
  endfunction

  // Magnitude of a signed WIDTH-bit value (most negative maps to itself).
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
    abs_w = v[WIDTH-1] ? neg_w(v) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product upper half / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;     // multiplier bits / dividend-then-quotient bits
  logic [WIDTH-1:0] b_q, b_d;       // multiplicand / divisor magnitude
  logic             is_div_q, is_div_d;
  logic             neg_q_q, neg_q_d;   // negate product (mult) or quotient (div)
  logic             neg_r_q, neg_r_d;   // negate remainder (dividend negative)
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Datapath arithmetic for one iteration step and for final sign correction.
  always_comb begin
    signed_op = ~op[0];
    mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_trial = {acc_q, sh_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_q};
    prod_raw  = {acc_q, sh_q};
    if (neg_q_q) begin
      prod_fix = ~prod_raw + ONE_2W;
    end else begin
      prod_fix = prod_raw;
    end
    if (div0_q) begin
      quo_fix = {WIDTH{1'b1}};
    end else if (neg_q_q) begin
      quo_fix = neg_w(sh_q);
    end else begin
      quo_fix = sh_q;
    end
    if (neg_r_q) begin
      rem_fix = neg_w(acc_q);
    end else begin
      rem_fix = acc_q;
    end
  end

  // Next-state and register-update logic for the operation FSM and HI/LO.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_CALC;
          cnt_d    = CW'(WIDTH);
          acc_d    = {WIDTH{1'b0}};
          sh_d     = signed_op ? abs_w(A) : A;
          b_d      = signed_op ? abs_w(B) : B;
          is_div_d = op[1];
          neg_q_d  = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
          neg_r_d  = signed_op & A[WIDTH-1];
          div0_d   = op[1] & (B == {WIDTH{1'b0}});
        end else begin
          // MTHI/MTLO only land when no operation is being launched.
          if (hi_we) begin
            hi_d = wdata;
          end else begin
            hi_d = hi_q;
          end
          if (lo_we) begin
            lo_d = wdata;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      S_CALC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            // Restoring step: keep the subtraction only if it did not go negative.
            if (!div_diff[WIDTH]) begin
              acc_d = div_diff[WIDTH-1:0];
              sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = div_trial[WIDTH-1:0];
              sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = mul_sum[WIDTH:1];
            sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (abort) begin
          done_d = 1'b0;
        end else begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      sh_q     <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (WIDTH=32): stimulus pushes expected
// {hi,lo}; a monitor pops and compares on every done pulse.
module tb_mul_div_unit;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          abort;
  logic          hi_we;
  logic          lo_we;
  logic [W-1:0]  wdata;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(a), .B(b),
    .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected done", 64'd1, 64'd0);
      end else begin
        chk("result {hi,lo}", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Launch one operation; optional start injection, busy-time MTHI, abort or reset.
  task automatic run_op(input string name, input logic [1:0] op_i,
                        input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [63:0] exp_i, input bit expect_done,
                        input int inject_at, input int we_busy_at,
                        input int abort_at, input int reset_at,
                        input bit mt_clash, input logic [W-1:0] pre_lo);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    @(negedge clk);
    op = op_i; a = a_i; b = b_i; start = 1'b1;
    if (mt_clash) begin
      lo_we = 1'b1;
      wdata = 32'hFFFF0000;
    end
    if (expect_done) exp_q.push_back(exp_i);
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      hi_we = 1'b0;
      if (n == 1) begin
        start = 1'b0;
        lo_we = 1'b0;
        if (mt_clash) chk({name, " lo after clash"}, {32'd0, lo}, {32'd0, pre_lo});
      end
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_at = n;
        chk({name, " busy at done"}, {63'd0, busy}, 64'd0);
        break;
      end
      if (n == inject_at) begin
        start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd1;
      end else if (inject_at != 0 && n == inject_at + 1) begin
        start = 1'b0;
      end
      if (n == we_busy_at) begin
        hi_we = 1'b1;
        wdata = 32'h12345678;
      end
      if (abort_at != 0 && n == abort_at) abort = 1'b1;
      if (reset_at != 0 && n == reset_at) rst_n = 1'b0;
      if ((abort_at != 0 && n == abort_at + 1) || (reset_at != 0 && n == reset_at + 1)) begin
        chk({name, " busy,done after flush"}, {62'd0, busy, done}, 64'd0);
        chk({name, " {hi,lo} after flush"}, {hi, lo}, exp_i);
        abort = 1'b0;
        rst_n = 1'b1;
        break;
      end
    end
    abort = 1'b0;
    rst_n = 1'b1;
    if (expect_done) begin
      chk({name, " done cycle"}, 64'(done_at), 64'(W + 2));
      chk({name, " busy cycles"}, 64'(busy_cnt), 64'(W + 1));
    end else begin
      repeat (45) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset {hi,lo}", {hi, lo}, 64'd0);
    chk("reset busy,done", {62'd0, busy, done}, 64'd0);
    rst_n = 1'b1;

    run_op("MULT neg*pos", 2'b00, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA, 1, 0, 0, 0, 0, 0, 0);
    run_op("MULTU max*max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1, 5, 0, 0, 0, 0, 0);
    repeat (40) @(negedge clk);  // any done from the ignored start would show here
    run_op("DIV -7/2", 2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1, 0, 0, 0, 0, 0, 0);
    run_op("DIVU", 2'b11, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 1, 0, 0, 0, 0, 0, 0);
    run_op("MULT neg*neg", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1, 0, 0, 0, 0, 0, 0);
    run_op("DIV 7/-2", 2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1, 0, 0, 0, 0, 0, 0);
    run_op("DIV -16/0", 2'b10, 32'hFFFFFFF0, 32'h00000000, 64'hFFFFFFF0_FFFFFFFF, 1, 0, 0, 0, 0, 0, 0);
    run_op("DIVU by 0", 2'b11, 32'h12345678, 32'h00000000, 64'h12345678_FFFFFFFF, 1, 0, 0, 0, 0, 0, 0);
    run_op("DIV overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1, 0, 0, 0, 0, 0, 0);

    // MTHI in IDLE
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    hi_we = 1'b0;
    chk("MTHI", {hi, lo}, 64'hAAAA5555_80000000);

    // MULTU aborted at 10th busy cycle, with MTHI attempted while busy
    run_op("MULTU abort", 2'b01, 32'h00000003, 32'h00000004, 64'hAAAA5555_80000000, 0, 0, 3, 10, 0, 0, 0);

    // abort and start together in IDLE: start dropped
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort beats start busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("abort beats start {hi,lo}", {hi, lo}, 64'hAAAA5555_80000000);

    // MTHI and MTLO together
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0F0F0F0F;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("MTHI+MTLO", {hi, lo}, 64'h0F0F0F0F_0F0F0F0F);

    // reset during 20th busy cycle of DIV, then MULT with an MTLO clash
    run_op("DIV reset", 2'b10, 32'd100, 32'd7, 64'd0, 0, 0, 0, 0, 20, 0, 0);
    run_op("MULT after reset", 2'b00, 32'h00000005, 32'h00000007, 64'h00000000_00000023, 1, 0, 0, 0, 0, 1, 32'h00000000);

    repeat (5) @(negedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
